exu_wbck_arb: RTL and testbench

- Writeback arbiter and sequencer for the integer regfile write port.
- Sits between two writeback sources and the regfile:
  - the single-cycle ALU;
  - the long-pipe unit (LSU loads, multi-cycle mul/div).
- Each cycle it grants at most one source and registers the selected write for one cycle before driving the regfile.
- Long-pipe has default priority. A starvation counter guarantees ALU forward progress.

---
 rtl/exu_wbck_arb_pkg.sv | 14 +
 rtl/exu_wbck_arb_if.sv | 34 +++
 rtl/exu_wbck_starve_cnt.sv | 37 +++
 rtl/exu_wbck_arb.sv | 61 ++++++
 tb/tb_exu_wbck_arb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/exu_wbck_arb_pkg.sv
// Shared widths and types for the integer writeback arbiter.
package exu_wbck_arb_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned RFIDX_WIDTH  = 5;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef struct packed {
    logic                   ena;
    logic [XLEN-1:0]        wdat;
    logic [RFIDX_WIDTH-1:0] rdidx;
  } rf_wbck_t;

endpackage

// File: rtl/exu_wbck_arb_if.sv
// Writeback request/response bundle between the two sources, the arbiter and the regfile.
interface exu_wbck_arb_if;
  import exu_wbck_arb_pkg::*;

  logic                   alu_wbck_i_valid;
  logic                   alu_wbck_i_ready;
  logic [XLEN-1:0]        alu_wbck_i_wdat;
  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx;

  logic                   longp_wbck_i_valid;
  logic                   longp_wbck_i_ready;
  logic [XLEN-1:0]        longp_wbck_i_wdat;
  logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx;
  logic                   longp_wbck_i_err;

  logic                   rf_wbck_o_ena;
  logic [XLEN-1:0]        rf_wbck_o_wdat;
  logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx;

  modport master (
    output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    output longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx, longp_wbck_i_err,
    input  alu_wbck_i_ready, longp_wbck_i_ready,
    input  rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
  );

  modport slave (
    input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    input  longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx, longp_wbck_i_err,
    output alu_wbck_i_ready, longp_wbck_i_ready,
    output rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
  );

endinterface

// File: rtl/exu_wbck_starve_cnt.sv
// Saturating count of consecutive ALU arbitration losses; sat forces the next ALU grant.
module exu_wbck_starve_cnt
  import exu_wbck_arb_pkg::*;
#(
  parameter int unsigned Max = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [STARVE_CNT_W-1:0] MaxW = STARVE_CNT_W'(Max);

  logic [STARVE_CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxW)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MaxW);

endmodule

// File: rtl/exu_wbck_arb.sv
// Integer regfile writeback arbiter: long-pipe priority with bounded ALU starvation,
// one registered write per cycle.
module exu_wbck_arb
  import exu_wbck_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  exu_wbck_arb_if.slave  wbck
);

  logic     force_alu;
  logic     grant_longp;
  logic     grant_alu;
  rf_wbck_t rf_d, rf_q;

  exu_wbck_starve_cnt #(
    .Max (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (wbck.alu_wbck_i_valid & grant_longp),
    .clr_i (grant_alu),
    .sat_o (force_alu)
  );

  assign grant_longp = wbck.longp_wbck_i_valid & ~(wbck.alu_wbck_i_valid & force_alu);
  assign grant_alu   = wbck.alu_wbck_i_valid & ~grant_longp;

  assign wbck.alu_wbck_i_ready   = grant_alu;
  assign wbck.longp_wbck_i_ready = grant_longp;

  // Data and index hold when idle; only the enable is a per-cycle pulse.
  always_comb begin
    rf_d     = rf_q;
    rf_d.ena = 1'b0;
    if (grant_alu) begin
      rf_d.ena   = (wbck.alu_wbck_i_rdidx != '0);
      rf_d.wdat  = wbck.alu_wbck_i_wdat;
      rf_d.rdidx = wbck.alu_wbck_i_rdidx;
    end else if (grant_longp) begin
      rf_d.ena   = ~wbck.longp_wbck_i_err & (wbck.longp_wbck_i_rdidx != '0);
      rf_d.wdat  = wbck.longp_wbck_i_wdat;
      rf_d.rdidx = wbck.longp_wbck_i_rdidx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign wbck.rf_wbck_o_ena   = rf_q.ena;
  assign wbck.rf_wbck_o_wdat  = rf_q.wdat;
  assign wbck.rf_wbck_o_rdidx = rf_q.rdidx;

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Self-checking bench for exu_wbck_arb: directed scenarios plus randomized traffic
// compared every cycle against a behavioural arbitration model.
module tb_exu_wbck_arb;
  import exu_wbck_arb_pkg::*;

  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  exu_wbck_arb_if bus ();

  exu_wbck_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wbck  (bus)
  );

  always #5 clk = ~clk;

  // Model state: how many times in a row the ALU has been passed over, and the
  // write the regfile should currently be seeing.
  int              alu_losses = 0;
  logic            exp_ena    = 1'b0;
  logic [31:0]     exp_wdat   = '0;
  logic [4:0]      exp_rdidx  = '0;

  function automatic logic longp_wins(logic lv, logic av, int losses);
    return lv && !(av && losses >= int'(STARVE_MAX));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_losses = 0;
      exp_ena    = 1'b0;
      exp_wdat   = '0;
      exp_rdidx  = '0;
    end else if (longp_wins(bus.longp_wbck_i_valid, bus.alu_wbck_i_valid, alu_losses)) begin
      if (bus.alu_wbck_i_valid && alu_losses < int'(STARVE_MAX)) alu_losses = alu_losses + 1;
      exp_ena   = !bus.longp_wbck_i_err && bus.longp_wbck_i_rdidx != 0;
      exp_wdat  = bus.longp_wbck_i_wdat;
      exp_rdidx = bus.longp_wbck_i_rdidx;
    end else if (bus.alu_wbck_i_valid) begin
      alu_losses = 0;
      exp_ena    = bus.alu_wbck_i_rdidx != 0;
      exp_wdat   = bus.alu_wbck_i_wdat;
      exp_rdidx  = bus.alu_wbck_i_rdidx;
    end else begin
      exp_ena = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic lw;
      lw = longp_wins(bus.longp_wbck_i_valid, bus.alu_wbck_i_valid, alu_losses);
      check("longp_ready", 32'(bus.longp_wbck_i_ready), 32'(lw));
      check("alu_ready", 32'(bus.alu_wbck_i_ready), 32'(bus.alu_wbck_i_valid && !lw));
      check("ready_excl", 32'(bus.alu_wbck_i_ready & bus.longp_wbck_i_ready), 32'd0);
      check("rf_ena", 32'(bus.rf_wbck_o_ena), 32'(exp_ena));
      check("rf_wdat", bus.rf_wbck_o_wdat, exp_wdat);
      check("rf_rdidx", 32'(bus.rf_wbck_o_rdidx), 32'(exp_rdidx));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(logic v, logic [31:0] d, logic [4:0] idx);
    bus.alu_wbck_i_valid = v;
    bus.alu_wbck_i_wdat  = d;
    bus.alu_wbck_i_rdidx = idx;
  endtask

  task automatic drive_lp(logic v, logic [31:0] d, logic [4:0] idx, logic err);
    bus.longp_wbck_i_valid = v;
    bus.longp_wbck_i_wdat  = d;
    bus.longp_wbck_i_rdidx = idx;
    bus.longp_wbck_i_err   = err;
  endtask

  int exp3 [6] = '{10, 11, 12, 13, 20, 14};

  initial begin
    logic lp_held;
    int   lgr;
    rst_n = 1'b0;
    drive_alu(1'b0, '0, '0);
    drive_lp(1'b0, '0, '0, 1'b0);
    repeat (2) step();
    check("rst_ena", 32'(bus.rf_wbck_o_ena), 32'd0);
    check("rst_wdat", bus.rf_wbck_o_wdat, 32'd0);
    check("rst_rdidx", 32'(bus.rf_wbck_o_rdidx), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_rdy", 32'({bus.alu_wbck_i_ready, bus.longp_wbck_i_ready}), 32'd0);

    // ALU-only write, then idle
    drive_alu(1'b1, 32'hDEADBEEF, 5'd5);
    #1 check("t2_alu_rdy", 32'(bus.alu_wbck_i_ready), 32'd1);
    step();
    drive_alu(1'b0, '0, '0);
    check("t2_ena", 32'(bus.rf_wbck_o_ena), 32'd1);
    check("t2_wdat", bus.rf_wbck_o_wdat, 32'hDEADBEEF);
    check("t2_rdidx", 32'(bus.rf_wbck_o_rdidx), 32'd5);
    step();
    check("t2_idle_ena", 32'(bus.rf_wbck_o_ena), 32'd0);
    check("t2_hold_wdat", bus.rf_wbck_o_wdat, 32'hDEADBEEF);

    // Both valid: four long-pipe wins, then a forced ALU win
    lgr = 0;
    for (int i = 0; i < 6; i++) begin
      drive_alu(1'b1, 32'hA000_0000, 5'd20);
      drive_lp(1'b1, 32'hB000_0000 + 32'(lgr), 5'(10 + lgr), 1'b0);
      #1 check("t3_lp_rdy", 32'(bus.longp_wbck_i_ready), 32'(i != 4));
      step();
      if (i != 4) lgr++;
      check("t3_rdidx", 32'(bus.rf_wbck_o_rdidx), 32'(exp3[i]));
    end
    drive_alu(1'b0, '0, '0);

    // Faulted long-pipe result is consumed but not written
    drive_lp(1'b1, 32'h1234, 5'd7, 1'b1);
    #1 check("t4_lp_rdy", 32'(bus.longp_wbck_i_ready), 32'd1);
    step();
    check("t4_err_ena", 32'(bus.rf_wbck_o_ena), 32'd0);
    check("t4_err_rdidx", 32'(bus.rf_wbck_o_rdidx), 32'd7);
    drive_lp(1'b1, 32'h1234, 5'd7, 1'b0);
    step();
    check("t4_ok_ena", 32'(bus.rf_wbck_o_ena), 32'd1);
    check("t4_ok_wdat", bus.rf_wbck_o_wdat, 32'h1234);

    // Build up losses, then an x0 ALU write must clear them
    drive_alu(1'b1, 32'h1, 5'd1);
    repeat (2) step();
    drive_lp(1'b0, '0, '0, 1'b0);
    drive_alu(1'b1, 32'hFFFFFFFF, 5'd0);
    #1 check("t5_alu_rdy", 32'(bus.alu_wbck_i_ready), 32'd1);
    step();
    check("t5_x0_ena", 32'(bus.rf_wbck_o_ena), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive_alu(1'b1, 32'h2, 5'd2);
      drive_lp(1'b1, 32'h3 + 32'(i), 5'd3, 1'b0);
      #1 check("t5_cleared", 32'(bus.alu_wbck_i_ready), 32'(i == 4));
      step();
    end

    // Alternating single requests: one write every cycle
    for (int i = 0; i < 8; i++) begin
      drive_alu(i % 2 == 0, 32'hC0 + 32'(i), 5'(1 + i));
      drive_lp(i % 2 == 1, 32'hD0 + 32'(i), 5'(1 + i), 1'b0);
      step();
      check("t6_ena", 32'(bus.rf_wbck_o_ena), 32'd1);
      check("t6_rdidx", 32'(bus.rf_wbck_o_rdidx), 32'(1 + i));
    end

    // Randomized traffic; long-pipe holds its request while not granted
    lp_held = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      drive_alu($urandom_range(0, 2) != 0, $urandom, 5'($urandom_range(0, 31)));
      if (!lp_held)
        drive_lp($urandom_range(0, 2) != 0, $urandom, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 7) == 0);
      lp_held = bus.longp_wbck_i_valid &&
                !longp_wins(bus.longp_wbck_i_valid, bus.alu_wbck_i_valid, alu_losses);
      step();
    end

    // Asynchronous reset while a write is pending
    drive_lp(1'b0, '0, '0, 1'b0);
    drive_alu(1'b1, 32'h5A5A5A5A, 5'd9);
    step();
    drive_alu(1'b0, '0, '0);
    check("pre_rst_ena", 32'(bus.rf_wbck_o_ena), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_ena", 32'(bus.rf_wbck_o_ena), 32'd0);
    check("async_rst_wdat", bus.rf_wbck_o_wdat, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
